// File: rtl/temp_osc_measure.sv
// Ring-oscillator temperature sensor back-end.
// Duty-cycles the analog oscillator (SETTLE -> COUNT -> OFF), counts rising
// edges of the synchronized oscillator output during the COUNT window and
// publishes a saturated 8-bit result with a one-cycle valid strobe.
module temp_osc_measure #(
  parameter int SETTLE_CYCLES = 4,
  parameter int WINDOW_CYCLES = 64,
  parameter int OFF_CYCLES    = 8
) (
  input  logic       lf_clk,
  input  logic       rst,
  input  logic       ana_clk,
  output logic       ana_en,
  output logic [7:0] delta,
  output logic       delta_valid
);

  typedef enum logic [1:0] {
    SETTLE,
    COUNT,
    OFF
  } state_t;

  // SETTLE leaves when the phase reaches SETTLE_CYCLES. After reset the phase
  // starts at 0, so the reset cycle itself (oscillator still off) acts as the
  // lead-in; re-entries from OFF start at phase 1 so every later SETTLE lasts
  // exactly SETTLE_CYCLES cycles with the oscillator enabled.
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES);
  localparam logic [15:0] WINDOW_LAST = 16'(WINDOW_CYCLES - 1);
  localparam logic [15:0] OFF_LAST    = 16'(OFF_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [15:0] phase;
  logic [15:0] phase_next;
  logic [7:0]  edges;
  logic [7:0]  edges_next;
  logic [7:0]  total;
  logic        s1;
  logic        s2;
  logic        s3;
  logic        rise;
  logic        done;

  // Two-flop synchronizer plus history flop; runs in every state.
  always_ff @(posedge lf_clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= ana_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise  = s2 & ~s3;
  // Saturating edge total including any edge detected in the current cycle.
  assign total = (rise && (edges != 8'hFF)) ? edges + 8'd1 : edges;

  // Next-state, phase and edge-counter logic.
  always_comb begin
    state_next = state;
    phase_next = phase + 16'd1;
    edges_next = edges;
    done       = 1'b0;
    case (state)
      SETTLE: begin
        if (phase == SETTLE_LAST) begin
          state_next = COUNT;
          phase_next = 16'd0;
          edges_next = 8'd0;
        end
      end
      COUNT: begin
        edges_next = total;
        if (phase == WINDOW_LAST) begin
          state_next = OFF;
          phase_next = 16'd0;
          done       = 1'b1;
        end
      end
      OFF: begin
        if (phase == OFF_LAST) begin
          state_next = SETTLE;
          phase_next = 16'd1;
        end
      end
      default: begin
        state_next = SETTLE;
        phase_next = 16'd0;
      end
    endcase
  end

  // State, counters and registered outputs; ana_en follows the state being entered.
  always_ff @(posedge lf_clk or posedge rst) begin
    if (rst) begin
      state       <= SETTLE;
      phase       <= 16'd0;
      edges       <= 8'd0;
      ana_en      <= 1'b0;
      delta       <= 8'd0;
      delta_valid <= 1'b0;
    end else begin
      state       <= state_next;
      phase       <= phase_next;
      edges       <= edges_next;
      ana_en      <= (state_next != OFF);
      delta_valid <= done;
      if (done) begin
        delta <= total;
      end
    end
  end

endmodule

// File: tb/tb_temp_osc_measure.sv
// Bench for temp_osc_measure: a default instance and a long-window instance
// (saturation) are checked every cycle against a timeline model built from
// edge indices since reset release, plus literal expectations at strobes.
`timescale 1ns/1ps
module tb_temp_osc_measure;

  logic       lf_clk = 1'b0;
  logic       rst0, rst1, ana0, ana1;
  logic       en0, en1, dv0, dv1;
  logic [7:0] d0, d1;

  int tests = 0;
  int fails = 0;

  int scyc[2] = '{4, 4};
  int wcyc[2] = '{64, 1024};
  int ocyc[2] = '{8, 8};
  int div_v[2];
  int tick_v[2];
  int n_v[2];
  int exp_d[2];
  bit pulse_v[2];
  bit hist[2][0:4095];

  always #10 lf_clk = ~lf_clk;

  temp_osc_measure dut (
    .lf_clk(lf_clk), .rst(rst0), .ana_clk(ana0),
    .ana_en(en0), .delta(d0), .delta_valid(dv0)
  );

  temp_osc_measure #(.WINDOW_CYCLES(1024)) dut_sat (
    .lf_clk(lf_clk), .rst(rst1), .ana_clk(ana1),
    .ana_en(en1), .delta(d1), .delta_valid(dv1)
  );

  function automatic logic get_rst(int i);
    return (i == 0) ? rst0 : rst1;
  endfunction
  function automatic logic get_ana(int i);
    return (i == 0) ? ana0 : ana1;
  endfunction
  function automatic logic get_en(int i);
    return (i == 0) ? en0 : en1;
  endfunction
  function automatic logic get_dv(int i);
    return (i == 0) ? dv0 : dv1;
  endfunction
  function automatic logic [7:0] get_d(int i);
    return (i == 0) ? d0 : d1;
  endfunction

  task automatic set_ana(int i, logic v);
    if (i == 0) ana0 = v;
    else ana1 = v;
  endtask

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_near(string name, int act, int exp, int tol);
    tests++;
    if (act < exp - tol || act > exp + tol) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d+-%0d (t=%0t)", name, act, exp, tol, $time);
    end
  endtask

  // Waits for the next strobe of instance i; returns edges counted from the call.
  task automatic wait_strobe(int i, int max_edges, output int edges);
    edges = -1;
    for (int e = 1; e <= max_edges; e++) begin
      @(posedge lf_clk);
      #1;
      if (get_dv(i)) begin
        edges = e;
        return;
      end
    end
    tests++;
    fails++;
    $display("FAIL strobe_timeout[%0d]: no delta_valid within %0d edges", i, max_edges);
  endtask

  // Oscillator stimulus: toggles every div/2 lf_clk cycles, off the clock edge.
  initial begin
    forever begin
      @(negedge lf_clk);
      #3;
      for (int i = 0; i < 2; i++) begin
        if (div_v[i] == 0) begin
          set_ana(i, 1'b0);
          tick_v[i] = 0;
        end else begin
          tick_v[i]++;
          if (tick_v[i] >= div_v[i] / 2) begin
            set_ana(i, !get_ana(i));
            tick_v[i] = 0;
          end
        end
      end
    end
  end

  // Model and per-cycle compare. n = lf_clk edges since reset release.
  initial begin
    int p, sw, n, cnt;
    bit st;
    for (int i = 0; i < 2; i++) begin
      n_v[i] = 0;
      exp_d[i] = 0;
    end
    forever begin
      @(posedge lf_clk);
      for (int i = 0; i < 2; i++) begin
        if (get_rst(i)) begin
          n_v[i] = 0;
          exp_d[i] = 0;
          pulse_v[i] = 1'b0;
        end else begin
          if (pulse_v[i]) begin
            n_v[i] = 0;
            exp_d[i] = 0;
            pulse_v[i] = 1'b0;
          end
          if (n_v[i] < 4095) n_v[i]++;
          hist[i][n_v[i]] = get_ana(i);
        end
      end
      #1;
      for (int i = 0; i < 2; i++) begin
        n  = n_v[i];
        sw = scyc[i] + wcyc[i];
        p  = sw + ocyc[i];
        st = (n >= sw + 1) && (((n - sw - 1) % p) == 0);
        if (st) begin
          // Samples taken at edge k are counted if k lies in [n-W-1, n-2].
          cnt = 0;
          for (int k = n - wcyc[i] - 1; k <= n - 2; k++)
            if (k >= 1 && hist[i][k] && !hist[i][k-1]) cnt++;
          exp_d[i] = (cnt > 255) ? 255 : cnt;
        end
        chk($sformatf("ana_en[%0d] n=%0d", i, n), int'(get_en(i)),
            int'((n > 0) && (((n - 1) % p) < sw)));
        chk($sformatf("delta_valid[%0d] n=%0d", i, n), int'(get_dv(i)), int'(st));
        chk($sformatf("delta[%0d] n=%0d", i, n), int'(get_d(i)), exp_d[i]);
        chk($sformatf("valid_with_en[%0d] n=%0d", i, n), int'(get_dv(i) && get_en(i)), 0);
      end
    end
  end

  task automatic seq0();
    int e;
    wait_strobe(0, 100, e);
    chk("first_strobe_edges", e, 69);
    chk("delta_idle_1", int'(d0), 0);
    wait_strobe(0, 100, e);
    chk("period_idle", e, 76);
    chk("delta_idle_2", int'(d0), 0);
    div_v[0] = 4;
    repeat (2) begin
      wait_strobe(0, 100, e);
      chk("period_div4", e, 76);
      chk_near("delta_div4", int'(d0), 16, 1);
    end
    div_v[0] = 8;
    repeat (2) begin
      wait_strobe(0, 100, e);
      chk_near("delta_div8", int'(d0), 8, 1);
    end
    div_v[0] = 16;
    wait_strobe(0, 100, e);
    wait_strobe(0, 100, e);
    chk_near("delta_div16", int'(d0), 4, 1);
    // Short asynchronous reset pulse in the middle of COUNT.
    repeat (40) @(posedge lf_clk);
    @(negedge lf_clk);
    #2;
    rst0 = 1'b1;
    pulse_v[0] = 1'b1;
    #1;
    chk("async_rst_ana_en", int'(en0), 0);
    chk("async_rst_delta", int'(d0), 0);
    chk("async_rst_valid", int'(dv0), 0);
    #2;
    rst0 = 1'b0;
    wait_strobe(0, 100, e);
    chk("strobe_after_rst", e, 69);
  endtask

  task automatic seq1();
    int e;
    wait_strobe(1, 1100, e);
    chk("sat_first_strobe", e, 1029);
    chk("sat_delta", int'(d1), 255);
    div_v[1] = 0;
    wait_strobe(1, 1100, e);
    chk("sat_period", e, 1036);
    chk("sat_then_zero", int'(d1), 0);
  endtask

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    ana0 = 1'b0;
    ana1 = 1'b0;
    div_v[0] = 0;
    div_v[1] = 4;
    tick_v[0] = 0;
    tick_v[1] = 0;
    repeat (3) @(negedge lf_clk);
    chk("reset_ana_en", int'(en0), 0);
    chk("reset_delta", int'(d0), 0);
    chk("reset_valid", int'(dv0), 0);
    rst0 = 1'b0;
    rst1 = 1'b0;
    fork
      seq0();
      seq1();
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/temp_osc_measure.md
# temp_osc_measure

Digital back-end for the ring-oscillator temperature sensor. Runs entirely on the 32.768 kHz real-time clock `lf_clk`. It duty-cycles the analog oscillator through `ana_en`, and while the oscillator is enabled it counts rising edges of the oscillator output `ana_clk` over a fixed window. Each result is published as an 8-bit `delta` with a one-cycle `delta_valid` strobe, for use by system firmware or a logging bench.

## Interface
- `SETTLE_CYCLES`, default 4: `lf_clk` cycles the oscillator runs before counting starts (≥1).
- `WINDOW_CYCLES`, default 64: length of the counting window in `lf_clk` cycles (≥1, ≤65535).
- `OFF_CYCLES`, default 8: `lf_clk` cycles the oscillator stays off between measurements (≥1).
- `lf_clk  in  1`: the block's only clock. All flops are clocked on its rising edge.
- `rst  in  1`: reset, asynchronous, active-high. All flops are cleared while it is high.
- `ana_clk  in  1`: oscillator output. Asynchronous to `lf_clk`; treated as data, never as a clock.
- `ana_en  out  1`: oscillator power-up/enable. Registered.
- `delta  out  8`: count from the most recent window. Registered; held between updates.
- `delta_valid  out  1`: one-cycle strobe marking a new `delta`. Registered.

## Operation
- Synchronizer: `ana_clk` passes through 2 flops (s1, s2) and a third history flop (s3).
  - A rising edge is detected in a cycle when `s2 & ~s3`.
  - The synchronizer runs in every state.
- FSM with states SETTLE, COUNT and OFF, each with a phase counter of at least 16 bits:
  - Reset enters SETTLE with the phase counter at 0.
  - SETTLE: `ana_en`=1 for SETTLE_CYCLES cycles, then go to COUNT and clear the edge counter.
  - COUNT: `ana_en`=1 for WINDOW_CYCLES cycles. Each detected edge increments the edge counter.
  - On the last COUNT cycle, load `delta` with the saturated total, including an edge detected in that same cycle. Then go to OFF.
  - OFF: `ana_en`=0 for OFF_CYCLES cycles, then go back to SETTLE.
- Edge counter arithmetic:
  - 9 bits wide, or saturating logic.
  - `delta` = min(edges, 255). It saturates at 255 and never wraps.
- `delta_valid` is 1 only in the first OFF cycle, when the new `delta` is first visible. It is 0 at all other times.
- Edges detected outside COUNT are ignored.
- The result is only meaningful when the `ana_clk` frequency is below `lf_clk`/2. Faster input aliases; this is documented, not detected.

## Timing
- Reset values:
  - `ana_en`=0, `delta`=0, `delta_valid`=0.
  - FSM in SETTLE, phase counter 0, edge counter 0, s1/s2/s3 = 0.
- `ana_en` rises on the first `lf_clk` edge after `rst` falls.
- Measurement period is SETTLE_CYCLES+WINDOW_CYCLES+OFF_CYCLES cycles: 76 cycles by default, i.e. 2.32 ms.
  - `ana_en` is high for SETTLE_CYCLES+WINDOW_CYCLES of those cycles (68 by default) and low for OFF_CYCLES (8).
- The first `delta_valid` arrives SETTLE_CYCLES+WINDOW_CYCLES+1 edges after reset release. Later ones are spaced exactly one period apart.
- `ana_en` falls on the same edge that `delta_valid` rises.
- Input latency:
  - An `ana_clk` rising edge is detected 2–3 `lf_clk` cycles after it occurs.
  - Count accuracy is ±1 edge per window.
- If `rst` is asserted mid-window:
  - All outputs drop to their reset values immediately.
  - The partial count is discarded; no `delta_valid` is produced for it.
  - A new full cycle starts after release.
- A saturated window reports 255, and the next window starts again from 0.

## Test plan
- `ana_clk` held at 0, defaults → every `delta_valid` pulse shows `delta`=0. `ana_en` is high for 68 cycles and low for 8, repeating.
- `ana_clk` toggling at `lf_clk`/4, asynchronous phase, defaults → `delta`=16±1 on each strobe. `delta_valid` is exactly one cycle wide and strobes are 76 cycles apart.
- `ana_clk` at `lf_clk`/8 → `delta`=8±1. Switching to `lf_clk`/16 mid-run gives a valid `delta`=4±1 by the second window after the change.
- `WINDOW_CYCLES`=1024 with `ana_clk` at `lf_clk`/4 → `delta`=255 (saturated). Then drop to 0 Hz and the next window reports 0.
- Assert `rst` for a few ns mid-COUNT → `ana_en`, `delta` and `delta_valid` go to 0 asynchronously. The first new strobe comes 69 edges after release.
- Check that `delta` holds its value between strobes, and that `delta_valid` never rises while `ana_en`=1.
